// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES block sequencer.
package des_ctrl_pkg;

  localparam int DES_BLK_W = 64;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/des_block_ctrl_if.sv
// Plaintext-in / ciphertext-out stream pair between the bus side and the
// DES sequencer. Signal names follow the sequencer's point of view.
interface des_block_ctrl_if;
  import des_ctrl_pkg::*;

  logic [DES_BLK_W-1:0] i_blk_data;
  logic                 i_blk_valid;
  logic                 i_blk_last;
  logic                 o_blk_ready;

  logic [DES_BLK_W-1:0] o_ct_data;
  logic                 o_ct_valid;
  logic                 o_ct_last;
  logic                 i_ct_ready;

  // Bus side: produces plaintext, consumes ciphertext.
  modport master (
    output i_blk_data, i_blk_valid, i_blk_last, i_ct_ready,
    input  o_blk_ready, o_ct_data, o_ct_valid, o_ct_last
  );

  // Sequencer side.
  modport slave (
    input  i_blk_data, i_blk_valid, i_blk_last, i_ct_ready,
    output o_blk_ready, o_ct_data, o_ct_valid, o_ct_last
  );

endinterface

// File: rtl/des_dv_edge.sv
// Rising-edge detector for the core's done flag. The previous value resets
// to 1 so a flag already high when reset releases never reads as an edge.
module des_dv_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dv,
  output logic o_rise
);

  logic dv_prev_q;
  logic dv_prev_d;

  // Previous-value tracks the raw flag every cycle, whatever the FSM is doing.
  always_comb begin
    dv_prev_d = i_dv;
  end

  // Previous-value register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dv_prev_q <= 1'b1;
    end else begin
      dv_prev_q <= dv_prev_d;
    end
  end

  assign o_rise = i_dv & ~dv_prev_q;

endmodule

// File: rtl/des_block_ctrl.sv
// Sequencer between the block stream and a single DES core: one block in
// flight, ECB or CBC chaining, watchdog on the core's completion.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no message; i_start latches key/mode/IV
//   LOAD  | ready for the next plaintext block
//   ISSUE | one-cycle o_des_dv pulse to the core, watchdog cleared
//   WAIT  | waiting for a rising edge of the core's dv, watchdog runs
//   OUT   | ciphertext presented until the sink takes it
//   ERR   | core never answered; sticky error, only i_start or reset leave
module des_block_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  des_block_ctrl_if.slave      bus,

  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic [DES_BLK_W-1:0] i_key,
  input  logic [DES_BLK_W-1:0] i_iv,

  output logic                 o_busy,
  output logic                 o_timeout_err,

  output logic [DES_BLK_W-1:0] o_des_cleartext,
  output logic [DES_BLK_W-1:0] o_des_key,
  output logic                 o_des_dv,
  input  logic [DES_BLK_W-1:0] i_des_ciphertext,
  input  logic                 i_des_dv
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [DES_BLK_W-1:0] key_q,   key_d;
  logic                 mode_q,  mode_d;
  logic [DES_BLK_W-1:0] chain_q, chain_d;
  logic [DES_BLK_W-1:0] clr_q,   clr_d;
  logic [DES_BLK_W-1:0] ct_q,    ct_d;
  logic                 last_q,  last_d;
  logic [CNT_W-1:0]     wdog_q,  wdog_d;
  logic                 err_q,   err_d;

  logic                 dv_rise;

  des_dv_edge u_dv_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_dv   (i_des_dv),
    .o_rise (dv_rise)
  );

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    chain_d = chain_q;
    clr_d   = clr_q;
    ct_d    = ct_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, ERR: begin
        if (i_start) begin
          key_d   = i_key;
          mode_d  = i_mode;
          chain_d = i_iv;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (bus.i_blk_valid) begin
          clr_d   = (mode_q == MODE_CBC) ? (bus.i_blk_data ^ chain_q) : bus.i_blk_data;
          last_d  = bus.i_blk_last;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A completion in the same cycle as the timeout still counts.
        if (dv_rise) begin
          ct_d    = i_des_ciphertext;
          chain_d = i_des_ciphertext;
          state_d = OUT;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_d  = wdog_q + CNT_W'(1);
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wdog_d  = wdog_q + CNT_W'(1);
        end
      end

      OUT: begin
        if (bus.i_ct_ready) begin
          state_d = last_q ? IDLE : LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      mode_q  <= MODE_ECB;
      chain_q <= '0;
      clr_q   <= '0;
      ct_q    <= '0;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      chain_q <= chain_d;
      clr_q   <= clr_d;
      ct_q    <= ct_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_blk_ready = (state_q == LOAD);
  assign bus.o_ct_valid  = (state_q == OUT);
  assign bus.o_ct_last   = (state_q == OUT) & last_q;
  assign bus.o_ct_data   = ct_q;

  assign o_des_dv        = (state_q == ISSUE);
  assign o_des_cleartext = clr_q;
  assign o_des_key       = key_q;
  assign o_busy          = (state_q != IDLE);
  assign o_timeout_err   = err_q;

endmodule
